// File: rtl/rbm_pkg.sv
// ============================================================================
// Module      : rbm_pkg
// Description : Shared widths, sigmoid constants and round-robin helper for
//               the RBM activation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rbm_pkg;

  localparam int RBM_INPUT_W   = 16;
  localparam int RBM_SIGMOID_W = 8;
  localparam int RBM_FRAC_BITS = 8;
  localparam int RR_MAX_REQ    = 16;

  localparam logic [7:0] SIG_MAX     = 8'hFF;
  localparam logic [7:0] SIG_HALF    = 8'h80;
  localparam logic [7:0] SIG_OFS_MID = 8'hA0;  // 0.625
  localparam logic [7:0] SIG_OFS_HI  = 8'hD8;  // 0.84375

  // Returns {found, index}; search starts just after 'last' and wraps at n_req.
  function automatic logic [4:0] rr_next(input logic [RR_MAX_REQ-1:0] valid,
                                         input logic [3:0]            last,
                                         input int                    n_req);
    logic [4:0] result;
    int         idx;
    result = '0;
    for (int k = 1; k <= RR_MAX_REQ; k++) begin
      idx = (int'(last) + k) % n_req;
      if (k <= n_req && !result[4] && valid[idx]) begin
        result = {1'b1, 4'(idx)};
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sigmoid.sv
// ============================================================================
// Module      : sigmoid
// Description : Piecewise-linear sigmoid, signed 8-fraction-bit input to an
//               unsigned probability where 0xFF ~ 1.0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmoid
  import rbm_pkg::*;
#(
  parameter int INPUT_BITLENGTH   = RBM_INPUT_W,
  parameter int SIGMOID_BITLENGTH = RBM_SIGMOID_W
) (
  input  logic [INPUT_BITLENGTH-1:0]   i_x,
  output logic [SIGMOID_BITLENGTH-1:0] o_y
);

  localparam logic [INPUT_BITLENGTH-1:0] c_bp_sat = INPUT_BITLENGTH'(5 << RBM_FRAC_BITS);
  localparam logic [INPUT_BITLENGTH-1:0] c_bp_hi  = INPUT_BITLENGTH'(19 << (RBM_FRAC_BITS - 3));
  localparam logic [INPUT_BITLENGTH-1:0] c_bp_lo  = INPUT_BITLENGTH'(1 << RBM_FRAC_BITS);

  logic                       w_neg;
  logic [INPUT_BITLENGTH-1:0] w_mag;
  logic [9:0]                 w_pos;
  logic [7:0]                 w_pos_sat;
  logic [7:0]                 w_y;

  assign w_neg = i_x[INPUT_BITLENGTH-1];
  assign w_mag = w_neg ? -i_x : i_x;

  // Output scale equals the input fraction scale, so slopes 2^-n are plain shifts.
  always_comb begin
    w_pos = '0;
    if (w_mag > c_bp_sat) begin
      w_pos = {2'b00, SIG_MAX};
    end else if (w_mag > c_bp_hi) begin
      w_pos = 10'(w_mag >> 5) + {2'b00, SIG_OFS_HI};
    end else if (w_mag > c_bp_lo) begin
      w_pos = 10'(w_mag >> 3) + {2'b00, SIG_OFS_MID};
    end else begin
      w_pos = 10'(w_mag >> 2) + {2'b00, SIG_HALF};
    end
  end

  assign w_pos_sat = (w_pos > {2'b00, SIG_MAX}) ? SIG_MAX : w_pos[7:0];
  assign w_y       = w_neg ? (SIG_MAX - w_pos_sat) : w_pos_sat;
  assign o_y       = SIGMOID_BITLENGTH'(w_y);

endmodule

`default_nettype wire

// File: rtl/sigmoid_scheduler.sv
// ============================================================================
// Module      : sigmoid_scheduler
// Description : Round-robin sharing of one sigmoid unit among N_REQ
//               requesters; two-stage pipeline with output backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmoid_scheduler
  import rbm_pkg::*;
#(
  parameter int N_REQ             = 4,
  parameter int INPUT_BITLENGTH   = RBM_INPUT_W,
  parameter int SIGMOID_BITLENGTH = RBM_SIGMOID_W,
  parameter int ID_W              = $clog2(N_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*INPUT_BITLENGTH-1:0]   req_sum,
  output logic [N_REQ-1:0]                   req_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SIGMOID_BITLENGTH-1:0]       out_data,
  output logic [ID_W-1:0]                    out_id
);

  logic [INPUT_BITLENGTH-1:0]   w_sums [N_REQ];
  logic                         w_adv_a;
  logic                         w_adv_b;
  logic                         w_grant;
  logic [4:0]                   w_rr;
  logic [ID_W-1:0]              w_gnt_idx;
  logic [SIGMOID_BITLENGTH-1:0] w_sig;

  logic                         r_a_valid;
  logic [INPUT_BITLENGTH-1:0]   r_a_sum;
  logic [ID_W-1:0]              r_a_id;
  logic [ID_W-1:0]              r_last;
  logic                         r_out_valid;
  logic [SIGMOID_BITLENGTH-1:0] r_out_data;
  logic [ID_W-1:0]              r_out_id;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_sums[g] = req_sum[g*INPUT_BITLENGTH +: INPUT_BITLENGTH];
  end

  assign w_adv_b   = !r_out_valid || out_ready;
  assign w_adv_a   = !r_a_valid || w_adv_b;
  assign w_rr      = rr_next(RR_MAX_REQ'(req_valid), 4'(r_last), N_REQ);
  // Gating with rst_n keeps requesters from seeing a grant that reset will discard.
  assign w_grant   = rst_n && w_adv_a && w_rr[4];
  assign w_gnt_idx = ID_W'(w_rr[3:0]);
  assign req_ready = w_grant ? (N_REQ'(1) << w_gnt_idx) : '0;

  sigmoid #(
    .INPUT_BITLENGTH   (INPUT_BITLENGTH),
    .SIGMOID_BITLENGTH (SIGMOID_BITLENGTH)
  ) u_sigmoid (
    .i_x (r_a_sum),
    .o_y (w_sig)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_valid   <= 1'b0;
      r_a_sum     <= '0;
      r_a_id      <= '0;
      r_last      <= ID_W'(N_REQ - 1);
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else begin
      if (w_adv_b) begin
        r_out_valid <= r_a_valid;
        r_out_data  <= w_sig;
        r_out_id    <= r_a_id;
      end
      if (w_adv_a) begin
        r_a_valid <= w_grant;
      end
      if (w_grant) begin
        r_a_sum <= w_sums[w_gnt_idx];
        r_a_id  <= w_gnt_idx;
        r_last  <= w_gnt_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_scheduler.sv
// ============================================================================
// Module      : tb_sigmoid_scheduler
// Description : Self-checking bench for sigmoid_scheduler with a scoreboard
//               and a behavioural arbitration / sigmoid reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sigmoid_scheduler;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int SW  = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_sum;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_data;
  logic [IDW-1:0]   out_id;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t sb[$];
  int   model_last = N - 1;

  always #5 clk = ~clk;

  sigmoid_scheduler #(
    .N_REQ             (N),
    .INPUT_BITLENGTH   (W),
    .SIGMOID_BITLENGTH (SW),
    .ID_W              (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sum   (req_sum),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  function automatic int ref_sig(input logic [15:0] x);
    int  xs;
    int  p;
    real a;
    real f;
    xs = int'($signed(x));
    a  = (xs < 0 ? -xs : xs) / 256.0;
    if (a > 5.0)        f = 255.0;
    else if (a > 2.375) f = 256.0 * (0.03125 * a + 0.84375);
    else if (a > 1.0)   f = 256.0 * (0.125 * a + 0.625);
    else                f = 256.0 * (0.25 * a + 0.5);
    p = int'($floor(f));
    if (p > 255) p = 255;
    return (xs < 0) ? 255 - p : p;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_sum();
    if ($urandom_range(0, 1) == 1) return W'($urandom_range(0, 3072)) - W'(1536);
    return W'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sum(input int i, input logic [W-1:0] v);
    req_sum[i*W +: W] = v;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Handshake monitor: sampled mid-cycle, before the edge that completes it.
  always @(negedge clk) begin
    int   w;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      model_last = N - 1;
    end else begin
      w = rr_pick(req_valid, model_last);
      if (out_ready && req_valid != '0) begin
        n_cmp++;
        if (req_ready == '0) begin
          n_fail++;
          $display("FAIL grant_when_free: req_ready=%b required nonzero (req_valid=%b)", req_ready, req_valid);
        end
      end
      if (req_ready != '0) begin
        n_cmp++;
        if (w < 0 || req_ready !== (N'(1) << w)) begin
          n_fail++;
          $display("FAIL arb_order: req_ready=%b required one-hot index %0d (req_valid=%b)", req_ready, w, req_valid);
        end else begin
          model_last = w;
          sb.push_back('{w, ref_sig(req_sum[w*W +: W])});
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: id=%0d data=%h with no outstanding request", out_id, out_data);
        end else begin
          e = sb.pop_front();
          if (out_id !== IDW'(e.id) || out_data !== SW'(e.data)) begin
            n_fail++;
            $display("FAIL result: id=%0d data=%h required id=%0d data=%h", out_id, out_data, e.id, e.data);
          end
        end
      end
    end
  end

  task automatic drain();
    tick();
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: out_valid=%b pending=%0d required 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_sum(i, rand_sum());
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 00", out_data); end
    n_cmp++;
    if (out_id !== '0) begin n_fail++; $display("FAIL reset_out_id: got %0d required 0", out_id); end
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [W-1:0]  vin  [6];
    logic [SW-1:0] vexp [6];
    vin  = '{16'h0000, 16'h0100, 16'hFF00, 16'h0600, 16'hFA00, 16'h8000};
    vexp = '{8'h80, 8'hC0, 8'h3F, 8'hFF, 8'h00, 8'h00};
    for (int t = 0; t < 6; t++) begin
      tick();
      set_sum(0, vin[t]);
      req_valid = 4'b0001;
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0001) begin
        n_fail++;
        $display("FAIL single_grant: req_ready=%b required 0001", req_ready);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_latency: out_valid=%b required 0 one edge after accept", out_valid);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== vexp[t] || out_id !== '0) begin
        n_fail++;
        $display("FAIL single_value: sum=%h got v=%b d=%h id=%0d required v=1 d=%h id=0",
                 vin[t], out_valid, out_data, out_id, vexp[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_sum(i, rand_sum());
    req_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== (N'(1) << (k % N))) begin
        n_fail++;
        $display("FAIL rr_grant: cycle %0d req_ready=%b required index %0d", k, req_ready, k % N);
      end
      if (k >= 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== IDW'((k - 2) % N)) begin
          n_fail++;
          $display("FAIL rr_out_id: cycle %0d out_valid=%b out_id=%0d required 1/%0d", k, out_valid, out_id, (k - 2) % N);
        end
      end
      tick();
      set_sum(k % N, rand_sum());
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g;
    logic [W-1:0] s0;
    int           acc;
    acc = 0;
    do_reset();
    for (int i = 0; i < N; i++) set_sum(i, rand_sum());
    s0        = req_sum[0 +: W];
    req_valid = '1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g = req_ready;
      if (req_ready != '0) acc++;
      if (k >= 2) begin
        n_cmp++;
        if (req_ready !== '0) begin
          n_fail++;
          $display("FAIL bp_full: cycle %0d req_ready=%b required 0000", k, req_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== '0 || out_data !== SW'(ref_sig(s0))) begin
          n_fail++;
          $display("FAIL bp_stable: cycle %0d v=%b id=%0d d=%h required 1/0/%h", k, out_valid, out_id, out_data, ref_sig(s0));
        end
      end
      tick();
      for (int i = 0; i < N; i++) if (g[i]) set_sum(i, rand_sum());
    end
    n_cmp++;
    if (acc != 2) begin
      n_fail++;
      $display("FAIL bp_accepts: %0d acceptances required 2", acc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release_grant: req_ready=%b required 0100", req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g = req_ready;
      tick();
      for (int i = 0; i < N; i++) if (g[i]) set_sum(i, rand_sum());
    end
    drain();
  endtask

  task automatic test_sparse();
    do_reset();
    for (int i = 0; i < N; i++) set_sum(i, rand_sum());
    req_valid = 4'b1010;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        n_fail++;
        $display("FAIL sparse_alt: cycle %0d req_ready=%b required %b", k, req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      end
      tick();
      set_sum((k % 2 == 0) ? 1 : 3, rand_sum());
    end
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL sparse_single: cycle %0d req_ready=%b required 0010", k, req_ready);
      end
      tick();
      set_sum(1, rand_sum());
    end
    drain();
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < N; i++) set_sum(i, rand_sum());
    req_valid = '1;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_full: req_ready=%b out_valid=%b required 0000/1", req_ready, out_valid);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL mr_ready_in_reset: req_ready=%b required 0000", req_ready);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_out_cleared: out_valid=%b required 0", out_valid);
    end
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mr_first_grant: req_ready=%b required 0001", req_ready);
    end
    tick();
    set_sum(0, rand_sum());
    out_ready = 1'b1;
    repeat (4) tick();
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    tick();
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (g[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_sum(i, rand_sum());
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
